serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Sequencer for a bit-serial adder. Each cycle it computes one bit with two chained half-adder stages plus a carry flop, so a WIDTH-bit add takes WIDTH cycles of shared single-bit logic.
- Sits between the switch/button input stage and the seven-segment/LED output stage.
- Uses a start/busy/done handshake. The result and carry-out are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start cycle.
- b  input  WIDTH  operand B; captured on the accepted start cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  registered result.
- co  output  1  registered final carry-out.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, co=0.
  - Internal shift registers, carry flop and bit counter are cleared.
- States: IDLE, RUN, DONE. Binary encoding; any illegal state goes to IDLE on the next edge.
- IDLE:
  - busy=0, done=0.
  - If start=1: capture a into opA and b into opB, clear carry=0 and cnt=0, go to RUN.
  - Otherwise stay in IDLE. sum and co keep their last values.
- RUN (busy=1), every cycle:
  - Half-adder 1: s1 = opA[0] ^ opB[0], c1 = opA[0] & opB[0].
  - Half-adder 2: bit = s1 ^ carry, c2 = s1 & carry.
  - carry <= c1 | c2.
  - Shift the result register right, inserting bit at MSB.
  - Shift opA and opB right, inserting 0.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1: this is the last bit; load sum from the final shifted value, load co from the final carry, go to DONE.
- DONE:
  - done=1 for exactly this one cycle, busy=0.
  - Next state is IDLE unconditionally.
  - start is ignored in DONE.
- Latency: start accepted at edge 0 gives busy high for edges 1..WIDTH, done high in cycle WIDTH+1.
- Throughput: one add per WIDTH+2 cycles.
- start while busy or done: ignored. Operands are not recaptured and there is no queueing.
- a and b may change freely after the accepted start cycle without affecting the operation.
- sum and co update only at the RUN-to-DONE transition. During RUN they hold the previous result.
- Reset mid-RUN: the operation is aborted and sum/co are cleared. No done pulse is issued.
- Arithmetic: unsigned, modulo 2^WIDTH. co is bit WIDTH of a+b.
- cnt width is clog2(WIDTH)+1 bits.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured together with the operands on the accepted start.
  - If sub=1: opB is loaded as ~b and the carry flop initialises to 1, giving sum = a - b mod 2^WIDTH.
  - co=1 means no borrow (a >= b unsigned).
  - Latency is unchanged.
- Undefined:
  - No sub port.
  - Behaves as addition only; carry always initialises to 0.

Test Plan (WIDTH=8):
- Reset then idle: after reset is held 2 cycles, sum=0x00, co=0, busy=0, done=0. With start=0 for 20 cycles, outputs do not change.
- Basic add: a=0x5A, b=0x3C, start pulsed 1 cycle. busy high for 8 cycles; done pulses in cycle 9 after start; sum=0x96, co=0; values held afterwards.
- Carry chain and wrap: a=0xFF, b=0x01 gives sum=0x00, co=1. a=0xFF, b=0xFF gives sum=0xFE, co=1.
- Start during busy: a=0x10, b=0x20 started. At cycle 3 drive start=1 with a=0xAA, b=0xAA. Only one done pulse occurs, sum=0x30; the second request is ignored.
- Reset mid-op: start with a=0x0F, b=0x01, assert reset at cycle 4. Next cycle state is IDLE, busy=0, sum=0x00, and no done pulse. A following start with a=0x01, b=0x02 gives sum=0x03.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x05, b=0x07 gives sum=0xFE, co=0. sub=1, a=0x07, b=0x05 gives sum=0x02, co=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one result bit per cycle from two chained half-adders
// plus a carry flop. Start/busy/done handshake; sum and co hold until the next add.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input selecting a - b (two's complement).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic             s1;
    logic             c1;
    logic             bit_out;
    logic             c2;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

    // Operand B and carry seed for the accepted start; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load     = sub ? ~b : b;
        carry_init = sub;
`else
        b_load     = b;
        carry_init = 1'b0;
`endif
    end

    // Shared single-bit datapath: two half-adders in series and the next result word.
    always_comb begin
        s1         = op_a_q[0] ^ op_b_q[0];
        c1         = op_a_q[0] & op_b_q[0];
        bit_out    = s1 ^ carry_q;
        c2         = s1 & carry_q;
        carry_next = c1 | c2;
        res_next   = {bit_out, res_q[WIDTH-1:1]};
    end

    // Sequencer FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            co      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= b_load;
                        carry_q <= carry_init;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    carry_q <= carry_next;
                    res_q   <= res_next;
                    op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
                    op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CntW'(1);
                    // Last bit: publish the result as it is shifted in.
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        sum     <= res_next;
                        co      <= carry_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
